// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI write or
// read burst-free transaction and returns the slave's data/response.
module axi4lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              A_CLK,
  input  logic              A_RSTn,
  // command / response side
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic [1:0]        RSP_RESP,
  // AXI write channels
  output logic              AW_VALID,
  input  logic              AW_READY,
  output logic [ADDR_W-1:0] AW_ADDR,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic [DATA_W-1:0] W_DATA,
  input  logic              B_VALID,
  output logic              B_READY,
  input  logic [1:0]        B_RESP,
  // AXI read channels
  output logic              AR_VALID,
  input  logic              AR_READY,
  output logic [ADDR_W-1:0] AR_ADDR,
  input  logic              R_VALID,
  output logic              R_READY,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  state_t state;

  // NOTE: every register here updates with <= so all outputs see the
  // pre-edge values of each other; blocking = would create ordering races.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      state     <= IDLE;
      CMD_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_RESP  <= 2'b00;
      AW_VALID  <= 1'b0;
      AW_ADDR   <= '0;
      W_VALID   <= 1'b0;
      W_DATA    <= '0;
      B_READY   <= 1'b0;
      AR_VALID  <= 1'b0;
      AR_ADDR   <= '0;
      R_READY   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          CMD_READY <= 1'b1;
          if (CMD_VALID && CMD_READY) begin
            CMD_READY <= 1'b0;
            if (CMD_WRITE) begin
              AW_ADDR  <= CMD_ADDR;
              W_DATA   <= CMD_WDATA;
              AW_VALID <= 1'b1;
              W_VALID  <= 1'b1;
              state    <= WR_REQ;
            end else begin
              AR_ADDR  <= CMD_ADDR;
              AR_VALID <= 1'b1;
              state    <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          // A low VALID here means that channel's handshake already happened.
          if (AW_VALID && AW_READY) AW_VALID <= 1'b0;
          if (W_VALID && W_READY)   W_VALID  <= 1'b0;
          if ((!AW_VALID || AW_READY) && (!W_VALID || W_READY)) begin
            B_READY <= 1'b1;
            state   <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (B_VALID && B_READY) begin
            B_READY   <= 1'b0;
            RSP_RESP  <= B_RESP;
            RSP_RDATA <= '0;
            RSP_VALID <= 1'b1;
            state     <= DONE;
          end
        end

        RD_REQ: begin
          if (AR_VALID && AR_READY) begin
            AR_VALID <= 1'b0;
            R_READY  <= 1'b1;
            state    <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (R_VALID && R_READY) begin
            R_READY   <= 1'b0;
            RSP_RDATA <= R_DATA;
            RSP_RESP  <= R_RESP;
            RSP_VALID <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (RSP_VALID && RSP_READY) begin
            RSP_VALID <= 1'b0;
            CMD_READY <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          CMD_READY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master: zero-wait and stalled slaves, error
// pass-through, response back-pressure and mid-transaction reset.
module tb_axi4lite_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [31:0] aw_addr, w_data;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] ar_addr, r_data;
  logic [1:0]  r_resp;

  int n_vec = 0;
  int n_bad = 0;
  int aw_cnt, w_cnt, b_cnt;

  axi4lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .A_CLK     (clk),
    .A_RSTn    (rst_n),
    .CMD_VALID (cmd_valid),
    .CMD_READY (cmd_ready),
    .CMD_WRITE (cmd_write),
    .CMD_ADDR  (cmd_addr),
    .CMD_WDATA (cmd_wdata),
    .RSP_VALID (rsp_valid),
    .RSP_READY (rsp_ready),
    .RSP_RDATA (rsp_rdata),
    .RSP_RESP  (rsp_resp),
    .AW_VALID  (aw_valid),
    .AW_READY  (aw_ready),
    .AW_ADDR   (aw_addr),
    .W_VALID   (w_valid),
    .W_READY   (w_ready),
    .W_DATA    (w_data),
    .B_VALID   (b_valid),
    .B_READY   (b_ready),
    .B_RESP    (b_resp),
    .AR_VALID  (ar_valid),
    .AR_READY  (ar_ready),
    .AR_ADDR   (ar_addr),
    .R_VALID   (r_valid),
    .R_READY   (r_ready),
    .R_DATA    (r_data),
    .R_RESP    (r_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake counters, cleared by the stimulus before each transaction.
  always @(posedge clk) begin
    if (aw_valid && aw_ready) aw_cnt++;
    if (w_valid && w_ready)   w_cnt++;
    if (b_valid && b_ready)   b_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    aw_cnt = 0;
    w_cnt  = 0;
    b_cnt  = 0;
  endtask

  // Zero-wait write with RSP_READY held high: accept, WR_REQ, WR_RESP, DONE -> IDLE.
  task automatic write_zw(input logic [31:0] a, input logic [31:0] d, input logic [1:0] br);
    check("wr pre cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = br; rsp_ready = 1'b1;
    clear_counts();
    tick();
    cmd_valid = 1'b0; cmd_wdata = 32'hFFFF_FFFF; cmd_addr = 32'hFFFF_FFFF;
    check("wr aw_valid", aw_valid, 1'b1);
    check("wr w_valid", w_valid, 1'b1);
    check("wr aw_addr", aw_addr, a);
    check("wr w_data", w_data, d);
    check("wr cmd_ready busy", cmd_ready, 1'b0);
    tick();
    check("wr aw_valid dropped", aw_valid, 1'b0);
    check("wr w_valid dropped", w_valid, 1'b0);
    check("wr b_ready", b_ready, 1'b1);
    tick();
    check("wr rsp_valid", rsp_valid, 1'b1);
    check("wr rsp_resp", rsp_resp, br);
    check("wr rsp_rdata", rsp_rdata, 32'h0);
    check("wr b_ready low", b_ready, 1'b0);
    tick();
    check("wr rsp_valid low", rsp_valid, 1'b0);
    check("wr cmd_ready 4cyc", cmd_ready, 1'b1);
    check("wr aw count", aw_cnt, 1);
    check("wr w count", w_cnt, 1);
    check("wr b count", b_cnt, 1);
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
  endtask

  // Zero-wait read with RSP_READY held high: accept, RD_REQ, RD_RESP, DONE -> IDLE.
  task automatic read_zw(input logic [31:0] a, input logic [31:0] rd, input logic [1:0] rr);
    check("rd pre cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
    ar_ready = 1'b1; r_valid = 1'b1; r_data = rd; r_resp = rr; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("rd ar_valid", ar_valid, 1'b1);
    check("rd ar_addr", ar_addr, a);
    check("rd no aw_valid", aw_valid, 1'b0);
    tick();
    check("rd ar_valid dropped", ar_valid, 1'b0);
    check("rd r_ready", r_ready, 1'b1);
    tick();
    check("rd rsp_valid", rsp_valid, 1'b1);
    check("rd rsp_rdata", rsp_rdata, rd);
    check("rd rsp_resp", rsp_resp, rr);
    check("rd r_ready low", r_ready, 1'b0);
    tick();
    check("rd cmd_ready 4cyc", cmd_ready, 1'b1);
    ar_ready = 1'b0; r_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
    clear_counts();

    // Reset state
    #1;
    check("rst cmd_ready", cmd_ready, 1'b0);
    check("rst valids", {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid}, 6'b0);
    check("rst addrs", {aw_addr, ar_addr}, 64'h0);
    check("rst data", {w_data, rsp_rdata}, 64'h0);
    check("rst rsp_resp", rsp_resp, 2'b00);
    tick();
    tick();
    check("rst held cmd_ready", cmd_ready, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    check("post-rst cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write then read-back
    write_zw(32'h4, 32'h1234_5678, 2'b00);
    read_zw(32'h4, 32'h1234_5678, 2'b00);

    // W accepted 3 cycles before AW
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hCAFE_F00D;
    w_ready = 1'b1; aw_ready = 1'b0; b_valid = 1'b0; rsp_ready = 1'b1;
    clear_counts();
    tick();
    cmd_valid = 1'b0;
    check("wo both valid", {aw_valid, w_valid}, 2'b11);
    tick();
    w_ready = 1'b0;
    check("wo w dropped", w_valid, 1'b0);
    check("wo aw held 1", aw_valid, 1'b1);
    tick();
    check("wo aw held 2", aw_valid, 1'b1);
    check("wo aw_addr stable", aw_addr, 32'h20);
    tick();
    check("wo aw held 3", aw_valid, 1'b1);
    check("wo b_ready early", b_ready, 1'b0);
    aw_ready = 1'b1;
    tick();
    aw_ready = 1'b0;
    check("wo aw dropped", aw_valid, 1'b0);
    check("wo b_ready", b_ready, 1'b1);
    tick();
    check("wo b_ready waits", b_ready, 1'b1);
    check("wo no rsp yet", rsp_valid, 1'b0);
    b_valid = 1'b1; b_resp = 2'b00;
    tick();
    b_valid = 1'b0;
    check("wo rsp_valid", rsp_valid, 1'b1);
    check("wo counts", {aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0]}, 24'h010101);
    tick();
    check("wo idle", cmd_ready, 1'b1);

    // Read: AR stalled, R_VALID delayed 5 cycles, SLVERR
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    ar_ready = 1'b0; r_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("se ar_valid", ar_valid, 1'b1);
    tick();
    check("se ar held", ar_valid, 1'b1);
    check("se ar_addr stable", ar_addr, 32'h10);
    check("se r_ready early", r_ready, 1'b0);
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    check("se ar dropped", ar_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("se r_ready stall", r_ready, 1'b1);
      check("se no rsp", rsp_valid, 1'b0);
      tick();
    end
    r_valid = 1'b1; r_data = 32'hDEAD_BEEF; r_resp = 2'b10;
    tick();
    r_valid = 1'b0; r_data = 32'h0; r_resp = 2'b00;
    check("se rsp_resp", rsp_resp, 2'b10);
    check("se rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);

    // Response back-pressure for 10 cycles, with a command knocking meanwhile
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h1;
    for (int i = 0; i < 10; i++) begin
      check("bp rsp_valid", rsp_valid, 1'b1);
      check("bp rsp stable", {rsp_rdata, 30'h0, rsp_resp}, {32'hDEAD_BEEF, 32'h2});
      check("bp cmd_ready", cmd_ready, 1'b0);
      check("bp no axi valid", {aw_valid, w_valid, ar_valid}, 3'b000);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp released", {rsp_valid, cmd_ready}, 2'b01);
    check("bp cmd ignored", {aw_valid, w_valid}, 2'b00);

    // DECERR write pass-through
    write_zw(32'h8, 32'h0BAD_0BAD, 2'b11);

    // Reset while AW_VALID is high
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h5555_AAAA;
    aw_ready = 1'b0; w_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("mr aw_valid before", aw_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr valids cleared", {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid}, 6'b0);
    check("mr cmd_ready", cmd_ready, 1'b0);
    check("mr aw_addr", aw_addr, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    check("mr cmd_ready after", cmd_ready, 1'b1);
    check("mr no rsp", rsp_valid, 1'b0);
    write_zw(32'hC, 32'hA5A5_5A5A, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4lite_master.md
AXI4LITE_MASTER -- requirements
Module: axi4lite_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width.
REQ-003 SHALL have port A_CLK, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port A_RSTn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports CMD_VALID in 1, CMD_READY out 1, CMD_WRITE in 1 (1=write, 0=read), CMD_ADDR in ADDR_W, CMD_WDATA in DATA_W.
REQ-006 SHALL have ports RSP_VALID out 1, RSP_READY in 1, RSP_RDATA out DATA_W, RSP_RESP out 2 (AXI response code).
REQ-007 SHALL have AXI write ports AW_VALID out 1, AW_READY in 1, AW_ADDR out ADDR_W, W_VALID out 1, W_READY in 1, W_DATA out DATA_W, B_VALID in 1, B_READY out 1, B_RESP in 2.
REQ-008 SHALL have AXI read ports AR_VALID out 1, AR_READY in 1, AR_ADDR out ADDR_W, R_VALID in 1, R_READY out 1, R_DATA in DATA_W, R_RESP in 2.

Function
REQ-009 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-010 SHALL drive CMD_READY=1 only in IDLE; command accepted when CMD_VALID&CMD_READY.
REQ-011 SHALL on accepted write latch CMD_ADDR/CMD_WDATA into AW_ADDR/W_DATA, go WR_REQ, assert AW_VALID and W_VALID together on the next cycle.
REQ-012 SHALL in WR_REQ hold AW_VALID until the AW_VALID&AW_READY cycle and W_VALID until the W_VALID&W_READY cycle, independently; either order or same cycle allowed.
REQ-013 SHALL leave WR_REQ for WR_RESP in the cycle after both AW and W handshakes have completed; B_READY=1 only in WR_RESP.
REQ-014 SHALL on B_VALID&B_READY capture B_RESP into RSP_RESP, set RSP_RDATA to 0, go DONE.
REQ-015 SHALL on accepted read latch CMD_ADDR into AR_ADDR, go RD_REQ, assert AR_VALID next cycle, hold until AR_VALID&AR_READY, then go RD_RESP.
REQ-016 SHALL assert R_READY=1 only in RD_RESP; on R_VALID&R_READY capture R_DATA into RSP_RDATA and R_RESP into RSP_RESP, go DONE.
REQ-017 SHALL assert RSP_VALID=1 only in DONE, holding RSP_RDATA/RSP_RESP stable until RSP_VALID&RSP_READY, then return to IDLE.
REQ-018 SHALL never drop an asserted AW_VALID, W_VALID or AR_VALID before its handshake, and never change AW_ADDR, W_DATA, AR_ADDR while the matching VALID is high.
REQ-019 SHALL have exactly one outstanding transaction; back-to-back throughput minimum: write 4 cycles, read 4 cycles with zero-wait slave and RSP_READY held 1.
REQ-020 SHALL pass SLVERR (2'b10) and DECERR (2'b11) through to RSP_RESP unchanged, with no retry.
REQ-021 SHALL drive all AXI VALID/READY outputs and RSP_VALID from registers (no combinational input-to-output paths).
REQ-022 SHALL ignore CMD_* inputs outside IDLE; CMD_WRITE and CMD_WDATA sampled only at acceptance.

Reset
REQ-023 SHALL on A_RSTn=0 immediately force state IDLE, AW_VALID=W_VALID=AR_VALID=B_READY=R_READY=RSP_VALID=0, CMD_READY=0.
REQ-024 SHALL reset AW_ADDR, W_DATA, AR_ADDR, RSP_RDATA to 0 and RSP_RESP to 2'b00.
REQ-025 SHALL assert CMD_READY=1 in the first clock after A_RSTn deasserts; a transaction in flight at reset is abandoned with no response.

Verification
REQ-026 SHALL pass: write addr 0x4 data 0x12345678, zero-wait slave -> one AW and one W handshake, B OKAY, RSP_VALID with RSP_RESP=00, RSP_RDATA=0.
REQ-027 SHALL pass: read addr 0x4 after above, slave returns 0x12345678 -> RSP_RDATA=0x12345678, RSP_RESP=00.
REQ-028 SHALL pass: write where W_READY arrives 3 cycles before AW_READY -> W_VALID drops after its handshake, AW_VALID held, single B accepted.
REQ-029 SHALL pass: read where slave returns R_RESP=2'b10 with R_READY stalled 5 cycles by slave delaying R_VALID -> RSP_RESP=10, AR_VALID held until AR_READY.
REQ-030 SHALL pass: RSP_READY held 0 for 10 cycles -> RSP_VALID/RSP_RDATA stable, CMD_READY=0, no new AXI VALID asserted.
REQ-031 SHALL pass: A_RSTn pulsed low while AW_VALID=1 -> all VALIDs 0 same cycle, CMD_READY=1 first cycle after release, next write completes normally.
